prog_round_counter: RTL

Parametrised, programmable round counter. It is the successor to the fixed 4-bit set/decrement counter used to sequence cipher rounds. It adds a programmable terminal value, up/down direction, start/pause control, an optional auto-reload mode, and explicit busy/done/terminal-count flags. It sits beside the round datapath: the controller programs it, starts it and steps it once per round, then waits for done.

---
 rtl/prog_round_counter_if.sv | 25 ++
 rtl/prog_round_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/prog_round_counter_if.sv
// Control/status bundle between the round controller (master) and the round counter (slave).
interface prog_round_counter_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             start;
  logic             pause;
  logic             step_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, dir, start, pause, step_en,
    input  count, busy, tc, done
  );

  modport slave (
    input  load, load_val, dir, start, pause, step_en,
    output count, busy, tc, done
  );
endinterface

// File: rtl/prog_round_counter.sv
// Programmable up/down round counter with start/pause, optional auto-reload and tc/done flags.
//
// state | meaning
// IDLE  | programmed, waiting for start
// RUN   | counting on step_en
// HOLD  | run frozen while pause is high
// DONE  | terminal value reached, count parked at T
module prog_round_counter #(
  parameter int                 WIDTH         = 5,
  parameter logic [WIDTH-1:0]   DEFAULT_LIMIT = {WIDTH{1'b1}},
  parameter bit                 AUTO_RELOAD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_round_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] stepped;

  assign start_val = dir_q ? ZERO : limit_q;
  assign term_val  = dir_q ? limit_q : ZERO;
  assign stepped   = dir_q ? (count_q + ONE) : (count_q - ONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;

    if (bus.load) begin
      // Reprogramming always abandons any run in progress without a tc.
      limit_d = bus.load_val;
      dir_d   = bus.dir;
      count_d = bus.dir ? ZERO : bus.load_val;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            count_d = start_val;
            if ((start_val == term_val) && !AUTO_RELOAD) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_HOLD;
          end else if (bus.step_en) begin
            if (count_q == term_val) begin
              // Only reachable with auto-reload: wrap back to the start value silently.
              count_d = start_val;
            end else begin
              count_d = stepped;
              if (stepped == term_val) begin
                tc_d = 1'b1;
                if (!AUTO_RELOAD) begin
                  state_d = ST_DONE;
                end
              end
            end
          end
        end
        ST_HOLD: begin
          if (!bus.pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= ZERO;
      limit_q <= DEFAULT_LIMIT;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.tc    = tc_q;

endmodule
